probe_arbiter: RTL and testbench

PROBE_ARBITER -- requirements
Module: probe_arbiter

---
 rtl/probe_arbiter_if.sv | 38 +++
 rtl/probe_arbiter.sv | 116 +++++++++++
 tb/tb_probe_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/probe_arbiter_if.sv
// probe_arbiter_if: handshake/bus bundle for the probe header arbiter.
//   req      : per-requester transaction request (level)
//   req_out  : per-requester pin drive values, requester k at [12k+11:12k]
//   req_dir  : per-requester pin directions, same packing, 1 = drive
//   pins_in  : probe pin read-back
//   pins_out : probe pin drive values
//   pins_dir : probe pin directions, 1 = drive
//   sample   : pins_in captured for the last completed transaction
//   done     : one-cycle completion pulse to the granted requester
//   grant_id : index of the current or most recent granted requester
//   busy     : arbiter is in a transaction (not IDLE)
// N_REQ must match the N_REQ of the attached probe_arbiter.
interface probe_arbiter_if #(
  parameter int unsigned N_REQ = 4
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ*12-1:0] req_out;
  logic [N_REQ*12-1:0] req_dir;
  logic [11:0]         pins_in;
  logic [11:0]         pins_out;
  logic [11:0]         pins_dir;
  logic [11:0]         sample;
  logic [N_REQ-1:0]    done;
  logic [2:0]          grant_id;
  logic                busy;

  // Requester / test-engine side
  modport master (
    output req, req_out, req_dir, pins_in,
    input  pins_out, pins_dir, sample, done, grant_id, busy
  );

  // Arbiter side
  modport slave (
    input  req, req_out, req_dir, pins_in,
    output pins_out, pins_dir, sample, done, grant_id, busy
  );
endinterface

// File: rtl/probe_arbiter.sv
// probe_arbiter: round-robin arbiter granting N_REQ test engines exclusive
// use of a 12-pin probe header. A transaction drives the granted requester's
// pin values, waits SETTLE_CYCLES, samples the pins, pulses done to that
// requester and releases the header to high-Z.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : probe_arbiter_if.slave (req/req_out/req_dir/pins_in in;
//         pins_out/pins_dir/sample/done/grant_id/busy out)
module probe_arbiter #(
  parameter int unsigned N_REQ         = 4,
  parameter int unsigned SETTLE_CYCLES = 8
) (
  input logic           clk,
  input logic           rst,
  probe_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, RELEASE} state_t;

  localparam logic [N_REQ-1:0] DONE_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       gid_q;
  logic [7:0]       cnt_q;
  logic [11:0]      pout_q;
  logic [11:0]      pdir_q;
  logic [11:0]      smp_q;
  logic [N_REQ-1:0] done_q;

  logic [7:0]  req_ext;
  logic [3:0]  idx;
  logic [2:0]  pick_d;
  logic        any_d;
  logic [11:0] drv_out_d;
  logic [11:0] drv_dir_d;

  assign req_ext = 8'(bus.req);

  // Round-robin search starting at ptr; the rotated index is folded back
  // into 0..N_REQ-1 by subtraction so it never reaches N_REQ.
  always_comb begin
    idx    = '0;
    pick_d = '0;
    any_d  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = 4'(ptr_q) + 4'(i);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      if (!any_d && req_ext[idx[2:0]]) begin
        any_d  = 1'b1;
        pick_d = idx[2:0];
      end
    end
  end

  always_comb begin
    drv_out_d = '0;
    drv_dir_d = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (3'(k) == pick_d) begin
        drv_out_d = bus.req_out[12*k +: 12];
        drv_dir_d = bus.req_dir[12*k +: 12];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      pout_q  <= '0;
      pdir_q  <= '0;
      smp_q   <= '0;
      done_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_d) begin
            gid_q   <= pick_d;
            pout_q  <= drv_out_d;
            pdir_q  <= drv_dir_d;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          cnt_q <= cnt_q + 8'd1;
          if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_q <= SAMPLE;
        end
        SAMPLE: begin
          smp_q   <= bus.pins_in;
          done_q  <= DONE_LSB << gid_q;
          state_q <= RELEASE;
        end
        RELEASE: begin
          done_q  <= '0;
          pdir_q  <= '0;
          pout_q  <= '0;
          ptr_q   <= (gid_q == 3'(N_REQ - 1)) ? '0 : gid_q + 3'd1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pins_out = pout_q;
  assign bus.pins_dir = pdir_q;
  assign bus.sample   = smp_q;
  assign bus.done     = done_q;
  assign bus.grant_id = gid_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_probe_arbiter.sv
// tb_probe_arbiter: scoreboard bench for probe_arbiter (N_REQ=4,
// SETTLE_CYCLES=8) with pins_in looped back from pins_out.
module tb_probe_arbiter;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  done;
    logic [2:0]  gid;
    logic [11:0] smp;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [3:0] prev_done;

  probe_arbiter_if #(.N_REQ(4)) bus ();

  probe_arbiter #(.N_REQ(4), .SETTLE_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.pins_in = bus.pins_out;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [11:0] s);
    exp_t e;
    e.done = 4'(1 << k);
    e.gid  = 3'(k);
    e.smp  = s;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [11:0] o, input logic [11:0] d);
    bus.req_out[12*k +: 12] = o;
    bus.req_dir[12*k +: 12] = d;
  endtask

  task automatic wait_drain(input int limit);
    for (int n = 0; n < limit && q.size() != 0; n++) begin
      @(negedge clk);
      #2;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic wait_idle(input int limit);
    for (int n = 0; n < limit && bus.busy; n++) tick(1);
    chk("idle_timeout", 32'(bus.busy), 32'd0);
  endtask

  // Monitor: every done pulse must match the oldest expected transaction.
  always @(negedge clk) begin
    if (rst) begin
      prev_done = '0;
    end else begin
      if (bus.done != '0) begin
        chk("done_onehot", 32'($onehot(bus.done)), 32'd1);
        chk("done_width", 32'(prev_done), 32'd0);
        if (q.size() == 0) begin
          chk("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          mon_e = q.pop_front();
          chk("sb_done", 32'(bus.done), 32'(mon_e.done));
          chk("sb_grant_id", 32'(bus.grant_id), 32'(mon_e.gid));
          chk("sb_sample", 32'(bus.sample), 32'(mon_e.smp));
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.req_out = '0;
    bus.req_dir = '0;
    tick(2);
    chk("rst_pins_dir", 32'(bus.pins_dir), 32'd0);
    chk("rst_pins_out", 32'(bus.pins_out), 32'd0);
    chk("rst_sample", 32'(bus.sample), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;

    // Single request, latency
    set_slice(2, 12'h005, 12'h003);
    bus.req = 4'b0100;
    push(2, 12'h005);
    tick(1);  // edge 0
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_grant_id", 32'(bus.grant_id), 32'd2);
    chk("t1_pins_dir", 32'(bus.pins_dir), 32'h003);
    chk("t1_pins_out", 32'(bus.pins_out), 32'h005);
    bus.req = '0;
    tick(8);  // edge 8
    chk("t1_done_e8", 32'(bus.done), 32'd0);
    tick(1);  // edge 9
    chk("t1_done_e9", 32'(bus.done), 32'b0100);
    chk("t1_sample", 32'(bus.sample), 32'h005);
    tick(1);  // edge 10
    chk("t1_pins_dir_e10", 32'(bus.pins_dir), 32'd0);
    chk("t1_done_e10", 32'(bus.done), 32'd0);
    chk("t1_busy_e10", 32'(bus.busy), 32'd0);

    // Fairness from a fresh pointer
    rst = 1'b1;
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) set_slice(k, 12'h1A0 + 12'(k), 12'hFFF);
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push(k, 12'h1A0 + 12'(k));
    bus.req = 4'b1111;
    wait_drain(200);
    bus.req = '0;
    wait_idle(20);

    // Serve requester 2 so ptr becomes 3, then wrap 3 -> 0
    set_slice(2, 12'h2C2, 12'hFFF);
    bus.req = 4'b0100;
    push(2, 12'h2C2);
    wait_drain(30);
    bus.req = '0;
    wait_idle(20);
    set_slice(3, 12'h3D3, 12'h0FF);
    set_slice(0, 12'h0E0, 12'hFF0);
    bus.req = 4'b1001;
    push(3, 12'h3D3);
    push(0, 12'h0E0);
    tick(1);
    chk("wrap_grant_id", 32'(bus.grant_id), 32'd3);
    wait_drain(60);
    bus.req = '0;
    wait_idle(20);

    // Late request raised during RELEASE (ptr = 1 here)
    set_slice(3, 12'h3A5, 12'hFFF);
    bus.req = 4'b1000;
    push(3, 12'h3A5);
    wait_drain(30);
    set_slice(0, 12'h0B6, 12'hFFF);
    bus.req = 4'b0001;
    push(0, 12'h0B6);
    tick(1);  // RELEASE edge
    chk("late_busy_rel", 32'(bus.busy), 32'd0);
    chk("late_gid_rel", 32'(bus.grant_id), 32'd3);
    chk("late_dir_rel", 32'(bus.pins_dir), 32'd0);
    tick(1);  // first IDLE edge
    chk("late_busy_grant", 32'(bus.busy), 32'd1);
    chk("late_gid_grant", 32'(bus.grant_id), 32'd0);
    chk("late_out_grant", 32'(bus.pins_out), 32'h0B6);
    bus.req = '0;
    wait_drain(30);
    wait_idle(20);

    // Drop req mid-transaction; req_out change after grant is ignored
    set_slice(1, 12'h15A, 12'hF0F);
    bus.req = 4'b0010;
    push(1, 12'h15A);
    tick(1);  // edge 0
    tick(2);  // edge 2
    set_slice(1, 12'hEEE, 12'h0F0);
    tick(1);  // edge 3
    chk("drop_pins_out", 32'(bus.pins_out), 32'h15A);
    chk("drop_pins_dir", 32'(bus.pins_dir), 32'hF0F);
    bus.req = '0;
    tick(6);  // edge 9
    chk("drop_done_e9", 32'(bus.done), 32'b0010);
    wait_drain(30);
    wait_idle(20);

    // Asynchronous reset mid-SETTLE
    set_slice(2, 12'h777, 12'hFFF);
    bus.req = 4'b0100;
    tick(1);  // grant
    tick(3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_pins_dir", 32'(bus.pins_dir), 32'd0);
    chk("arst_pins_out", 32'(bus.pins_out), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_grant_id", 32'(bus.grant_id), 32'd0);
    bus.req = '0;
    #1;
    rst = 1'b0;
    set_slice(1, 12'h321, 12'hFFF);
    bus.req = 4'b0010;
    push(1, 12'h321);
    tick(1);
    chk("arst_regrant_busy", 32'(bus.busy), 32'd1);
    chk("arst_regrant_gid", 32'(bus.grant_id), 32'd1);
    bus.req = '0;
    wait_drain(30);
    wait_idle(20);

    tick(15);
    chk("final_queue", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
